// File: rtl/ifetch_prefetch_if.sv
// Bus bundle between the fetch unit, instruction memory and the decoder.
// master = fetch unit side, slave = memory/decoder environment side.
interface ifetch_prefetch_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst_data;
   logic [ADDR_W-1:0] inst_pc;
   logic [ADDR_W-1:0] inst_link;
   logic [ADDR_W-1:0] branch_base;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output inst_valid, inst_data, inst_pc, inst_link, branch_base,
      input  inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  inst_valid, inst_data, inst_pc, inst_link, branch_base,
      output inst_ready
   );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction fetch unit with prefetch queue. Requests are only issued when
// the queue has room for every outstanding response, so the response path
// never needs backpressure. A redirect flushes the queue and marks all
// in-flight responses as stale (drop counter).
module ifetch_prefetch #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                DEPTH     = 4,
   parameter bit                LINK_WORD = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   ifetch_prefetch_if.master bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [CNT_W-1:0]  pending;
   logic [CNT_W-1:0]  drop;
   logic [CNT_W-1:0]  count;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [31:0]       q_data [DEPTH];
   logic [ADDR_W-1:0] q_pc   [DEPTH];

   logic [CNT_W:0]    in_use;
   logic              req_valid;
   logic              head_valid;
   logic              issue;
   logic              pop;
   logic              enq;
   logic [ADDR_W-1:0] target_al;
   logic [ADDR_W-1:0] head_pc;
   logic [ADDR_W-1:0] head_next;

   // Handshake qualification; nothing is offered during reset or a redirect.
   always_comb begin
      in_use     = {1'b0, count} + {1'b0, pending};
      req_valid  = !reset && !redirect_valid && (in_use < (CNT_W+1)'(DEPTH));
      head_valid = !reset && !redirect_valid && (count != '0);
      issue      = req_valid && bus.imem_req_ready;
      pop        = head_valid && bus.inst_ready;
      enq        = bus.imem_rsp_valid && (drop == '0) && !redirect_valid;
      target_al  = redirect_target & ~ADDR_W'(3);
      head_pc    = q_pc[rd_ptr];
      head_next  = head_pc + STEP;
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc;
   assign bus.inst_valid     = head_valid;
   assign bus.inst_data      = q_data[rd_ptr];
   assign bus.inst_pc        = head_pc;
   assign bus.inst_link      = LINK_WORD ? (head_next >> 2) : head_next;
   assign bus.branch_base    = head_next;

   // Fetch/response PCs, outstanding and stale counters, queue occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         pending  <= '0;
         drop     <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (redirect_valid) begin
         // Everything still in flight belongs to the old stream.
         fetch_pc <= target_al;
         resp_pc  <= target_al;
         pending  <= pending - CNT_W'(bus.imem_rsp_valid);
         drop     <= pending - CNT_W'(bus.imem_rsp_valid);
         count    <= '0;
         rd_ptr   <= wr_ptr;
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + STEP;
         end
         pending <= pending + CNT_W'(issue) - CNT_W'(bus.imem_rsp_valid);
         if (bus.imem_rsp_valid && (drop != '0)) begin
            drop <= drop - CNT_W'(1);
         end
         if (enq) begin
            resp_pc <= resp_pc + STEP;
            wr_ptr  <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(enq) - CNT_W'(pop);
      end
   end

   // Queue storage; contents are only meaningful between rd_ptr and wr_ptr.
   always_ff @(posedge clock) begin
      if (enq) begin
         q_data[wr_ptr] <= bus.imem_rsp_data;
         q_pc[wr_ptr]   <= resp_pc;
      end
   end

   // Issue rule guarantees space; an overflow means memory broke the protocol.
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (!(enq && !pop && (count == CNT_W'(DEPTH))));
         assert (!(bus.imem_rsp_valid && (pending == '0)));
      end
   end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with an in-order latency memory model
// and a scoreboard of expected instruction PCs.
module tb_ifetch_prefetch;
   localparam int          ADDR_W   = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;

   ifetch_prefetch_if #(.ADDR_W(ADDR_W)) bus ();

   ifetch_prefetch #(
      .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .LINK_WORD(1'b1)
   ) dut (
      .clock(clock), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .bus(bus)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   int          accepts = 0;
   int          pops = 0;
   logic [31:0] exp_q [$];
   logic [31:0] mq_addr [$];
   int          mq_due [$];
   logic [31:0] exp_fetch = RESET_PC;
   logic        req_ready_drv = 1'b1;
   logic        inst_ready_drv = 1'b1;
   logic        snap_req_valid, snap_inst_valid;
   logic [31:0] snap_req_addr, snap_inst_pc, snap_inst_link, snap_branch_base;
   logic [31:0] last_acc_addr = '0;
   logic [31:0] first_pc = '0;
   logic        got_first = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive inputs at negedge, observe handshakes, step past posedge.
   task automatic cycle(input logic rst, input logic redir, input logic [31:0] tgt);
      logic [31:0] e;
      logic [31:0] nxt;
      @(negedge clock);
      reset           = rst;
      redirect_valid  = redir;
      redirect_target = tgt;
      bus.imem_req_ready = req_ready_drv;
      bus.inst_ready     = inst_ready_drv;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (rst) begin
         mq_addr.delete();
         mq_due.delete();
         exp_q.delete();
         exp_fetch = RESET_PC;
      end else begin
         if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = ~mq_addr[0];
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end
         if (redir) begin
            exp_q.delete();
            exp_fetch = tgt & ~32'd3;
         end
      end
      #1;
      snap_req_valid   = bus.imem_req_valid;
      snap_req_addr    = bus.imem_req_addr;
      snap_inst_valid  = bus.inst_valid;
      snap_inst_pc     = bus.inst_pc;
      snap_inst_link   = bus.inst_link;
      snap_branch_base = bus.branch_base;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         chk("req_addr", bus.imem_req_addr, exp_fetch);
         accepts++;
         last_acc_addr = bus.imem_req_addr;
         mq_addr.push_back(exp_fetch);
         mq_due.push_back(cyc + lat);
         exp_q.push_back(exp_fetch);
         exp_fetch = exp_fetch + 32'd4;
      end
      if (bus.inst_valid && bus.inst_ready) begin
         pops++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_inst observed pc=%h expected=none", bus.inst_pc);
         end
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nxt = e + 32'd4;
            chk("inst_pc", bus.inst_pc, e);
            chk("inst_data", bus.inst_data, ~e);
            chk("inst_link", bus.inst_link, nxt >> 2);
            chk("branch_base", bus.branch_base, nxt);
         end
         if (!got_first) begin
            first_pc  = bus.inst_pc;
            got_first = 1'b1;
         end
      end
      @(posedge clock);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
   endtask

   initial begin
      int n;
      int np;
      logic [31:0] held;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.inst_ready     = 1'b0;

      // Reset, then a 1-cycle memory with everything ready.
      cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, '0);
      chk("rst_req_valid", 32'(snap_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(snap_inst_valid), 32'd0);
      lat = 1;
      run(1);
      chk("first_req_valid", 32'(snap_req_valid), 32'd1);
      chk("first_req_addr", snap_req_addr, 32'h0);
      run(1);
      chk("inst_valid_not_yet", 32'(snap_inst_valid), 32'd0);
      run(1);
      chk("first_inst_valid", 32'(snap_inst_valid), 32'd1);
      chk("first_inst_pc", snap_inst_pc, 32'h0);
      chk("first_inst_link", snap_inst_link, 32'h1);
      chk("first_branch_base", snap_branch_base, 32'h4);
      run(8);

      // Latency 3 with the decoder stalled: issue stops once DEPTH are in use.
      cycle(1'b1, 1'b0, '0);
      lat = 3;
      inst_ready_drv = 1'b0;
      accepts = 0;
      run(10);
      chk("full_accepts", 32'(accepts), 32'(DEPTH));
      chk("full_req_valid", 32'(snap_req_valid), 32'd0);
      inst_ready_drv = 1'b1;
      n = accepts;
      for (int i = 0; i < 10 && accepts == n; i++) run(1);
      chk("resume_addr", last_acc_addr, 32'h10);
      run(10);

      // Three outstanding, redirect while the oldest response lands.
      cycle(1'b1, 1'b0, '0);
      lat = 3;
      run(3);
      got_first = 1'b0;
      cycle(1'b0, 1'b1, 32'h103);
      chk("redir_req_valid", 32'(snap_req_valid), 32'd0);
      run(1);
      chk("redir_req_valid_next", 32'(snap_req_valid), 32'd1);
      chk("redir_req_addr", snap_req_addr, 32'h100);
      run(8);
      chk("redir_first_pc", first_pc, 32'h100);

      // Redirect while a head is being accepted: the pop is void.
      lat = 1;
      run(6);
      chk("stream_inst_valid", 32'(snap_inst_valid), 32'd1);
      got_first = 1'b0;
      np = pops;
      cycle(1'b0, 1'b1, 32'h200);
      chk("redir_inst_valid", 32'(snap_inst_valid), 32'd0);
      chk("redir_no_pop", 32'(pops), 32'(np));
      run(6);
      chk("redir2_first_pc", first_pc, 32'h200);

      // Back-to-back redirects: last one wins.
      got_first = 1'b0;
      cycle(1'b0, 1'b1, 32'h300);
      cycle(1'b0, 1'b1, 32'h402);
      run(6);
      chk("b2b_first_pc", first_pc, 32'h400);

      // Memory not ready: address holds, nothing accepted.
      req_ready_drv = 1'b0;
      run(1);
      held = snap_req_addr;
      n = accepts;
      for (int i = 0; i < 4; i++) begin
         run(1);
         chk("stall_addr", snap_req_addr, held);
         chk("stall_req_valid", 32'(snap_req_valid), 32'd1);
      end
      chk("stall_accepts", 32'(accepts), 32'(n));
      req_ready_drv = 1'b1;
      run(6);

      // Reset mid-operation with work outstanding and queued.
      lat = 2;
      inst_ready_drv = 1'b0;
      run(5);
      cycle(1'b1, 1'b0, '0);
      chk("midrst_inst_valid", 32'(snap_inst_valid), 32'd0);
      chk("midrst_req_valid", 32'(snap_req_valid), 32'd0);
      lat = 1;
      inst_ready_drv = 1'b1;
      run(1);
      chk("postrst_req_valid", 32'(snap_req_valid), 32'd1);
      chk("postrst_req_addr", snap_req_addr, RESET_PC);
      run(6);

      // Address wrap at the top of the space.
      got_first = 1'b0;
      cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
      run(1);
      chk("wrap_addr0", snap_req_addr, 32'hFFFF_FFFC);
      run(1);
      chk("wrap_addr1", snap_req_addr, 32'h0000_0000);
      run(6);
      chk("wrap_first_pc", first_pc, 32'hFFFF_FFFC);

      // Drain: stop issuing and let everything outstanding be delivered.
      req_ready_drv = 1'b0;
      for (int i = 0; i < 20 && (exp_q.size() != 0 || mq_addr.size() != 0); i++) run(1);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
